// File: rtl/sram_128x4096_arbiter.sv
// Two-requester req/gnt/rvalid arbiter in front of a single-port SRAM macro,
// with a zero-fill sweep after reset release and on request.
module sram_128x4096_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 128,
  parameter bit INIT_ON_RST = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                init_req_i,
  output logic                init_done_o,
  input  logic                req0_i,
  output logic                gnt0_o,
  input  logic                we0_i,
  input  logic [DATA_W/8-1:0] be0_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [DATA_W-1:0]   wdata0_i,
  output logic                rvalid0_o,
  output logic [DATA_W-1:0]   rdata0_o,
  input  logic                req1_i,
  output logic                gnt1_o,
  input  logic                we1_i,
  input  logic [DATA_W/8-1:0] be1_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   wdata1_i,
  output logic                rvalid1_o,
  output logic [DATA_W-1:0]   rdata1_o,
  output logic                sram_cen_o,
  output logic                sram_gwen_o,
  output logic [DATA_W-1:0]   sram_wen_o,
  output logic [ADDR_W-1:0]   sram_a_o,
  output logic [DATA_W-1:0]   sram_d_o,
  input  logic [DATA_W-1:0]   sram_q_i
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;
  localparam logic [0:0] ST_RESET = INIT_ON_RST ? ST_INIT : ST_SERVE;
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              resp_we_q, resp_we_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;

  logic              serving, sweeping, contested;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] be_wen;

  // rst_ni gates everything combinational so the macro pins go idle the moment reset asserts.
  assign serving   = rst_ni & (state_q == ST_SERVE);
  assign sweeping  = rst_ni & (state_q == ST_INIT);
  assign contested = serving & req0_i & req1_i;

  assign gnt0_o = serving & req0_i & (~req1_i | ~rr_q);
  assign gnt1_o = serving & req1_i & (~req0_i | rr_q);

  assign sel_we    = gnt1_o ? we1_i    : we0_i;
  assign sel_be    = gnt1_o ? be1_i    : be0_i;
  assign sel_addr  = gnt1_o ? addr1_i  : addr0_i;
  assign sel_wdata = gnt1_o ? wdata1_i : wdata0_i;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_wen
    assign be_wen[gi*8 +: 8] = {8{~sel_be[gi]}};
  end

  always_comb begin
    sram_cen_o  = 1'b1;
    sram_gwen_o = 1'b1;
    sram_wen_o  = '1;
    sram_a_o    = a_q;
    sram_d_o    = d_q;
    if (sweeping) begin
      sram_cen_o  = 1'b0;
      sram_gwen_o = 1'b0;
      sram_wen_o  = '0;
      sram_a_o    = cnt_q;
      sram_d_o    = '0;
    end else if (gnt0_o || gnt1_o) begin
      sram_cen_o = 1'b0;
      sram_a_o   = sel_addr;
      if (sel_we) begin
        sram_gwen_o = 1'b0;
        sram_wen_o  = be_wen;
        sram_d_o    = sel_wdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    rvalid0_d = gnt0_o;
    rvalid1_d = gnt1_o;
    resp_we_d = sel_we;
    a_d       = sram_a_o;
    d_d       = sram_d_o;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_SERVE;
        cnt_d   = '0;
      end
    end else if (init_req_i) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
    if (contested) begin
      rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      resp_we_q <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      resp_we_q <= resp_we_d;
      a_q       <= a_d;
      d_q       <= d_d;
    end
  end

  assign init_done_o = (state_q == ST_SERVE);
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  // Write responses carry zero data; the macro's Q is only meaningful after a read.
  assign rdata0_o    = (rvalid0_q && !resp_we_q) ? sram_q_i : '0;
  assign rdata1_o    = (rvalid1_q && !resp_we_q) ? sram_q_i : '0;

endmodule
